// File: rtl/tc_pl_cap_pkg.sv
// Shared definitions for the capture sequencer: state encoding, CRC constants,
// gain-step limits and the address stride of one 16-bit sample.
package tc_pl_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CAPT   = 2'd2,
    ST_DONE   = 2'd3
  } cap_state_e;

  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam int          NGAIN     = 4;
  localparam logic [31:0] ADDR_STEP = 32'd2;

  // Requested gain count above the hardware maximum is treated as the maximum.
  function automatic logic [2:0] clamp_ngain(input logic [2:0] n);
    return (n > 3'(NGAIN)) ? 3'(NGAIN) : n;
  endfunction

endpackage

// File: rtl/tc_pl_cap_crc16.sv
// Combinational next-state of the reflected CRC32 for one 16-bit word,
// data consumed LSB first.
module tc_pl_cap_crc16
  import tc_pl_cap_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [15:0] i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  // Bit-serial LFSR unrolled across the 16 data bits
  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 16; i++) begin
      if (w_c[0] ^ i_data[i]) w_c = (w_c >> 1) ^ CRC_POLY;
      else                    w_c = w_c >> 1;
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/tc_pl_cap_seq.sv
// Capture sequencer: on trigger, walks through up to NGAIN gain settings,
// settling before each and writing cycle x points samples per gain to memory,
// while accumulating a CRC32 and the elapsed clock count.
module tc_pl_cap_seq
  import tc_pl_cap_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int CW = 18,
  parameter int PW = 14
) (
  input  logic          i_clk125,
  input  logic          i_rst,
  input  logic          i_cap_trig,
  input  logic [2:0]    i_cap_gain_number,
  input  logic [31:0]   i_cap_gain_del,
  input  logic [PW-1:0] i_cap_points,
  input  logic [AW-1:0] i_cap_addr,
  input  logic [CW-1:0] i_cap_gain0_cycle,
  input  logic [CW-1:0] i_cap_gain1_cycle,
  input  logic [CW-1:0] i_cap_gain2_cycle,
  input  logic [CW-1:0] i_cap_gain3_cycle,
  input  logic [DW-1:0] i_adc_data,
  input  logic          i_adc_valid,
  output logic [1:0]    o_gain_sel,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_cap_cing,
  output logic          o_cap_cmpt,
  output logic [31:0]   o_cap_crc32,
  output logic [31:0]   o_cap_time
);

  cap_state_e                r_state;
  logic [2:0]                r_ngain;
  logic [31:0]               r_del;
  logic [PW-1:0]             r_points;
  logic [NGAIN-1:0][CW-1:0]  r_cyc;
  logic [2:0]                r_g;
  logic [31:0]               r_cnt;
  logic [AW-1:0]             r_wptr;
  logic [31:0]               r_crc;

  logic [1:0]    r_gain_sel;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_cing;
  logic          r_cmpt;
  logic [31:0]   r_crc_out;
  logic [31:0]   r_time;

  logic [31:0] w_total;
  logic [31:0] w_crc_next;
  logic [2:0]  w_g_next;
  logic [2:0]  w_ngain_in;
  logic        w_wr;
  logic        w_capt_end;

  // Samples for the active gain; CW+PW fits exactly in 32 bits
  assign w_total    = 32'(r_cyc[r_g[1:0]]) * 32'(r_points);
  assign w_g_next   = r_g + 3'd1;
  assign w_ngain_in = clamp_ngain(i_cap_gain_number);
  assign w_wr       = i_adc_valid && (w_total != 32'd0);
  // Gain step finishes on its last sample, or at once when it has none
  assign w_capt_end = (w_total == 32'd0) || (w_wr && (r_cnt == w_total - 32'd1));

  tc_pl_cap_crc16 u_crc (
    .i_crc  (r_crc),
    .i_data (16'(i_adc_data)),
    .o_crc  (w_crc_next)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge i_clk125) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ngain    <= '0;
      r_del      <= '0;
      r_points   <= '0;
      r_cyc      <= '0;
      r_g        <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_crc      <= '0;
      r_gain_sel <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cing     <= 1'b0;
      r_cmpt     <= 1'b0;
      r_crc_out  <= '0;
      r_time     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_cmpt  <= 1'b0;
      if (r_cing && (r_time != 32'hFFFF_FFFF)) r_time <= r_time + 32'd1;
      case (r_state)
        ST_IDLE: begin
          if (i_cap_trig) begin
            r_ngain   <= w_ngain_in;
            r_del     <= i_cap_gain_del;
            r_points  <= i_cap_points;
            r_cyc     <= {i_cap_gain3_cycle, i_cap_gain2_cycle,
                          i_cap_gain1_cycle, i_cap_gain0_cycle};
            r_g       <= '0;
            r_cnt     <= '0;
            r_crc     <= CRC_INIT;
            r_time    <= 32'd1;
            r_cing    <= 1'b1;
            r_wptr    <= i_cap_addr;
            r_wr_addr <= i_cap_addr;
            r_state   <= (w_ngain_in == 3'd0) ? ST_DONE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Zero delay still spends one cycle here
          r_gain_sel <= r_g[1:0];
          if (r_cnt + 32'd1 >= r_del) begin
            r_cnt   <= '0;
            r_state <= ST_CAPT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_CAPT: begin
          if (w_wr) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= i_adc_data;
            r_wr_addr <= r_wptr;
            r_wptr    <= r_wptr + AW'(ADDR_STEP);
            r_crc     <= w_crc_next;
          end
          if (w_capt_end) begin
            r_g     <= w_g_next;
            r_cnt   <= '0;
            r_state <= (w_g_next == r_ngain) ? ST_DONE : ST_SETTLE;
          end else if (w_wr) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_DONE: begin
          r_crc_out <= ~r_crc;
          r_cmpt    <= 1'b1;
          r_cing    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gain_sel  = r_gain_sel;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_cap_cing  = r_cing;
  assign o_cap_cmpt  = r_cmpt;
  assign o_cap_crc32 = r_crc_out;
  assign o_cap_time  = r_time;

endmodule

// File: tb/tb_tc_pl_cap_seq.sv
// Bench for the capture sequencer: a schedule-level model predicts every write,
// the busy window, the done pulse, CRC and elapsed time from the latched config.
module tb_tc_pl_cap_seq;

  logic        clk = 1'b0;
  logic        rst, trig, adc_valid;
  logic [2:0]  gnum;
  logic [31:0] del, addr;
  logic [13:0] points;
  logic [17:0] cy0, cy1, cy2, cy3;
  logic [15:0] adc_data;
  logic [1:0]  gain_sel;
  logic        wr_en, cing, cmpt;
  logic [31:0] wr_addr, crc32, ctime;
  logic [15:0] wr_data;

  always #4 clk = ~clk;

  tc_pl_cap_seq dut (
    .i_clk125(clk), .i_rst(rst), .i_cap_trig(trig), .i_cap_gain_number(gnum),
    .i_cap_gain_del(del), .i_cap_points(points), .i_cap_addr(addr),
    .i_cap_gain0_cycle(cy0), .i_cap_gain1_cycle(cy1), .i_cap_gain2_cycle(cy2),
    .i_cap_gain3_cycle(cy3), .i_adc_data(adc_data), .i_adc_valid(adc_valid),
    .o_gain_sel(gain_sel), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_cap_cing(cing), .o_cap_cmpt(cmpt), .o_cap_crc32(crc32), .o_cap_time(ctime)
  );

  typedef struct {
    int          e;
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  g;
  } wr_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int dbase = 0, dmul = 1, doff = 0;
  wr_t exq[$];
  int exp_e0 = 0, exp_done = 0;
  logic [31:0] exp_crc = 0, exp_time = 0;
  logic [31:0] obs_addr[$];
  logic [15:0] obs_data[$];
  logic [1:0]  obs_gain[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Sample value presented to the DUT for clock edge e
  function automatic logic [15:0] data_fn(int e);
    return 16'((e - dbase) * dmul + doff);
  endfunction

  function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predicts the whole capture for a trigger accepted at edge e0, using the
  // config inputs as they stand at that edge and continuous adc_valid.
  task automatic plan(int e0);
    int n, d, s;
    longint p;
    logic [31:0] a, c;
    logic [17:0] cy[4];
    wr_t w;
    cy = '{cy0, cy1, cy2, cy3};
    n = (gnum > 3'd4) ? 4 : int'(gnum);
    d = (del == 0) ? 1 : int'(del);
    a = addr;
    c = 32'hFFFFFFFF;
    s = e0 + 1;
    exq.delete();
    for (int g = 0; g < n; g++) begin
      p = longint'(cy[g]) * longint'(points);
      for (int j = 0; j < int'(p); j++) begin
        w.e = s + d + j;
        w.a = a;
        w.d = data_fn(w.e);
        w.g = 2'(g);
        exq.push_back(w);
        c = crc_byte(crc_byte(c, w.d[7:0]), w.d[15:8]);
        a = a + 32'd2;
      end
      s = s + d + ((p == 0) ? 1 : int'(p));
    end
    exp_e0   = e0;
    exp_done = (n == 0) ? e0 + 1 : s;
    exp_crc  = ~c;
    exp_time = 32'(exp_done - e0 + 1);
  endtask

  // Per-cycle compare of DUT outputs against the model
  initial begin
    forever begin
      bit ew;
      wr_t w;
      @(posedge clk);
      #1;
      ew = (exq.size() > 0) && (exq[0].e == cyc);
      chk("wr_en", 32'(wr_en), 32'(ew));
      if (wr_en) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
        obs_gain.push_back(gain_sel);
      end
      if (ew) begin
        w = exq.pop_front();
        if (wr_en) begin
          chk("wr_addr", wr_addr, w.a);
          chk("wr_data", 32'(wr_data), 32'(w.d));
          chk("gain_sel", 32'(gain_sel), 32'(w.g));
        end
      end
      chk("cap_cmpt", 32'(cmpt), 32'(exp_done != 0 && cyc == exp_done));
      chk("cap_cing", 32'(cing), 32'(exp_done != 0 && cyc >= exp_e0 && cyc < exp_done));
      if (exp_done != 0 && cyc == exp_done) begin
        chk("cap_crc32", crc32, exp_crc);
        chk("cap_time", ctime, exp_time);
      end
    end
  end

  initial begin
    adc_data = '0;
    forever begin
      @(negedge clk);
      adc_data = data_fn(cyc + 1);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(logic [2:0] gn, logic [31:0] dl, logic [13:0] pt, logic [31:0] ad,
                     logic [17:0] c0, logic [17:0] c1, logic [17:0] c2, logic [17:0] c3);
    gnum = gn; del = dl; points = pt; addr = ad;
    cy0 = c0; cy1 = c1; cy2 = c2; cy3 = c3;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_gain.delete();
  endtask

  task automatic start();
    clear_obs();
    trig = 1'b1;
    plan(cyc + 1);
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic finish_run();
    int lim;
    lim = 0;
    while (cyc <= exp_done + 1 && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 5000) chk("run_timeout", 32'(lim), 32'd0);
  endtask

  initial begin
    logic [31:0] pin;
    logic [7:0]  msg[9];
    rst = 1'b1; trig = 1'b0; adc_valid = 1'b1;
    cfg(3'd0, 32'd0, 14'd0, 32'd0, 18'd0, 18'd0, 18'd0, 18'd0);

    // Pin the CRC model with the standard check string "123456789"
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pin = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) pin = crc_byte(pin, msg[i]);
    chk("crc_model_check", ~pin, 32'hCBF43926);

    tick(3);
    chk("rst_cing", 32'(cing), 0);
    chk("rst_cmpt", 32'(cmpt), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_crc", crc32, 0);
    chk("rst_time", ctime, 0);
    chk("rst_gain_sel", 32'(gain_sel), 0);
    chk("rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    tick(1);

    // 1: single gain, samples 1..4
    cfg(3'd1, 32'd3, 14'd4, 32'h1000, 18'd1, 18'd0, 18'd0, 18'd0);
    dmul = 1; doff = 1; dbase = cyc + 1 + 4;
    start();
    finish_run();
    chk("t1_count", 32'(obs_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk("t1_addr", obs_addr[i], 32'h1000 + 32'(2 * i));
      chk("t1_data", 32'(obs_data[i]), 32'(i + 1));
    end
    chk("t1_time", ctime, 32'd9);

    // 2: four gains, continuous valid; inputs changed after trigger
    cfg(3'd4, 32'd10, 14'd3, 32'h2000, 18'd2, 18'd2, 18'd2, 18'd2);
    dmul = 32'h3A7; doff = 32'h1111; dbase = 0;
    start();
    cfg(3'd1, 32'd2, 14'd7, 32'h9000, 18'd5, 18'd5, 18'd5, 18'd5);
    finish_run();
    chk("t2_count", 32'(obs_addr.size()), 32'd24);
    chk("t2_time", ctime, 32'd66);
    if (obs_gain.size() == 24) chk("t2_last_gain", 32'(obs_gain[23]), 32'd3);

    // 3a: gain_number 7 clamps to 4
    cfg(3'd7, 32'd1, 14'd2, 32'h3000, 18'd1, 18'd1, 18'd1, 18'd1);
    start();
    finish_run();
    chk("t3_clamp_count", 32'(obs_addr.size()), 32'd8);

    // 3b: gain_number 0; trig held so the DONE-cycle trig is dropped and the next taken
    cfg(3'd0, 32'd5, 14'd2, 32'h4000, 18'd1, 18'd1, 18'd1, 18'd1);
    clear_obs();
    trig = 1'b1;
    plan(cyc + 1);
    tick(2);
    plan(cyc + 1);
    tick(1);
    trig = 1'b0;
    tick(3);
    chk("t3_zero_count", 32'(obs_addr.size()), 32'd0);
    chk("t3_zero_crc", crc32, 32'h0);
    chk("t3_zero_time", ctime, 32'd2);

    // 4a: trig mid-capture is ignored
    cfg(3'd1, 32'd2, 14'd5, 32'h5000, 18'd2, 18'd0, 18'd0, 18'd0);
    start();
    tick(6);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    finish_run();
    chk("t4_count", 32'(obs_addr.size()), 32'd10);

    // 4b: reset mid-capture aborts, then a fresh capture restarts at cap_addr
    start();
    tick(6);
    rst = 1'b1;
    exq.delete(); exp_e0 = 0; exp_done = 0;
    tick(2);
    chk("t4_rst_cing", 32'(cing), 0);
    chk("t4_rst_crc", crc32, 0);
    chk("t4_rst_time", ctime, 0);
    rst = 1'b0;
    tick(1);
    start();
    finish_run();
    chk("t4_restart_count", 32'(obs_addr.size()), 32'd10);
    if (obs_addr.size() > 0) chk("t4_restart_addr", obs_addr[0], 32'h5000);

    // 5: address wrap
    cfg(3'd1, 32'd0, 14'd4, 32'hFFFFFFFC, 18'd1, 18'd0, 18'd0, 18'd0);
    start();
    finish_run();
    chk("t5_count", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("t5_addr0", obs_addr[0], 32'hFFFFFFFC);
      chk("t5_addr1", obs_addr[1], 32'hFFFFFFFE);
      chk("t5_addr2", obs_addr[2], 32'h00000000);
      chk("t5_addr3", obs_addr[3], 32'h00000002);
    end

    // 6: empty middle gain is settled then skipped
    cfg(3'd3, 32'd4, 14'd3, 32'h6000, 18'd1, 18'd0, 18'd2, 18'd0);
    start();
    finish_run();
    chk("t6_count", 32'(obs_addr.size()), 32'd9);
    if (obs_gain.size() == 9) begin
      chk("t6_gain_first", 32'(obs_gain[2]), 32'd0);
      chk("t6_gain_second", 32'(obs_gain[3]), 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
